// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: Tuse/Tnew stall detection and MDU busy countdown for the 5-stage pipeline.
// Defining STALL_PERF_CNT_EN adds a 32-bit stall-cycle counter (stall_cycles, cleared by perf_clr).
module hazard_stall_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic       D_is_md,
    input  logic       D_flush,
    input  logic [4:0] E_A3,
    input  logic [1:0] E_Tnew,
    input  logic [4:0] M_A3,
    input  logic [1:0] M_Tnew,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    output logic       pc_en,
    output logic       FD_en,
    output logic       FD_clear,
    output logic       DE_clear,
    output logic       EM_en,
    output logic       md_busy,
    output logic       stall
`ifdef STALL_PERF_CNT_EN
    ,
    input  logic        perf_clr,
    output logic [31:0] stall_cycles
`endif
);

    logic [CNT_W-1:0] md_cnt;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;

    // A stall is needed when a producer in E or M will not have its result
    // ready by the time D consumes it; register $0 never creates a hazard.
    always_comb begin
        stall_rs = (D_rs != 5'd0) &&
                   (((E_A3 == D_rs) && (E_Tnew > D_Tuse_rs)) ||
                    ((M_A3 == D_rs) && (M_Tnew > D_Tuse_rs)));
        stall_rt = (D_rt != 5'd0) &&
                   (((E_A3 == D_rt) && (E_Tnew > D_Tuse_rt)) ||
                    ((M_A3 == D_rt) && (M_Tnew > D_Tuse_rt)));
        md_busy  = E_md_start || (md_cnt != '0);
        stall_md = D_is_md && md_busy;
        stall    = stall_rs | stall_rt | stall_md;
        pc_en    = !stall;
        FD_en    = !stall;
        DE_clear = stall;
        FD_clear = D_flush && !stall;
        EM_en    = 1'b1;
    end

    // A new mult/div start always reloads the window, even over a running one.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (E_md_start) begin
            md_cnt <= E_md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            stall_cycles <= 32'd0;
        end else if (stall) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench for hazard_stall_ctrl; expected output vectors are
// queued as stimulus is applied and compared at the following negedge.
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs, D_rt;
    logic [1:0] D_Tuse_rs, D_Tuse_rt;
    logic       D_is_md, D_flush;
    logic [4:0] E_A3, M_A3;
    logic [1:0] E_Tnew, M_Tnew;
    logic       E_md_start, E_md_is_div;
    logic       pc_en, FD_en, FD_clear, DE_clear, EM_en, md_busy, stall;
`ifdef STALL_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] stall_cycles;
`endif

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_is_md(D_is_md), .D_flush(D_flush),
        .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .pc_en(pc_en), .FD_en(FD_en), .FD_clear(FD_clear), .DE_clear(DE_clear),
        .EM_en(EM_en), .md_busy(md_busy), .stall(stall)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_clr(perf_clr), .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: stall, pc_en, FD_en, FD_clear, DE_clear, EM_en, md_busy
    logic [6:0] outs;
    assign outs = {stall, pc_en, FD_en, FD_clear, DE_clear, EM_en, md_busy};

    typedef struct {
        logic [6:0] vec;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t make_exp(input logic s, input logic fc, input logic b, input string n);
        exp_t e;
        e.vec  = {s, ~s, ~s, fc, s, 1'b1, b};
        e.name = n;
        return e;
    endfunction

    function automatic logic ref_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                        input logic [4:0] ea3, input logic [1:0] etn,
                                        input logic [4:0] ma3, input logic [1:0] mtn);
        return (r != 5'd0) && (((ea3 == r) && (etn > tuse)) || ((ma3 == r) && (mtn > tuse)));
    endfunction

    task automatic drive_idle();
        D_rs = 5'd0; D_rt = 5'd0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
        D_is_md = 1'b0; D_flush = 1'b0;
        E_A3 = 5'd0; E_Tnew = 2'd0; M_A3 = 5'd0; M_Tnew = 2'd0;
        E_md_start = 1'b0; E_md_is_div = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        drive_idle();
        D_Tuse_rs = 2'd0; D_Tuse_rt = 2'd0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) reset = 1'b0;
            sb.push_back(make_exp(1'b0, 1'b0, 1'b0, "reset_state"));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s[%0d]: got %b expected %b", e.name, i, outs, e.vec);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            case (i)
                0: begin
                    E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd0;
                    sb.push_back(make_exp(1'b1, 1'b0, 1'b0, "load_use_stall"));
                end
                1: begin
                    E_A3 = 5'd8; E_Tnew = 2'd1; M_A3 = 5'd8; M_Tnew = 2'd1;
                    D_rs = 5'd8; D_Tuse_rs = 2'd1;
                    sb.push_back(make_exp(1'b0, 1'b0, 1'b0, "load_use_resolved"));
                end
                2: begin
                    D_rt = 5'd9; M_A3 = 5'd9; M_Tnew = 2'd2; D_Tuse_rt = 2'd1;
                    sb.push_back(make_exp(1'b1, 1'b0, 1'b0, "rt_m_hazard"));
                end
                3: begin
                    E_A3 = 5'd8; E_Tnew = 2'd3; D_rs = 5'd8; D_Tuse_rs = 2'd3;
                    sb.push_back(make_exp(1'b0, 1'b0, 1'b0, "rs_unused"));
                end
                4: begin
                    D_flush = 1'b1;
                    sb.push_back(make_exp(1'b0, 1'b1, 1'b0, "flush_no_stall"));
                end
                default: begin
                    D_flush = 1'b1; E_A3 = 5'd3; E_Tnew = 2'd1; D_rt = 5'd3; D_Tuse_rt = 2'd0;
                    sb.push_back(make_exp(1'b1, 1'b0, 1'b0, "flush_blocked_by_hazard"));
                end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s: got %b expected %b", e.name, outs, e.vec);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        drive_idle();
        E_A3 = 5'd0; E_Tnew = 2'd2; D_rs = 5'd0; D_Tuse_rs = 2'd0;
        M_A3 = 5'd0; M_Tnew = 2'd3; D_rt = 5'd0; D_Tuse_rt = 2'd0;
        sb.push_back(make_exp(1'b0, 1'b0, 1'b0, "zero_reg_exempt"));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (outs !== e.vec) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, outs, e.vec);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_hazards();
        exp_t e;
        logic s;
        for (int i = 0; i < 24; i++) begin
            drive_idle();
            D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
            E_A3 = 5'($urandom_range(0, 3)); M_A3 = 5'($urandom_range(0, 3));
            D_Tuse_rs = 2'($urandom_range(0, 3)); D_Tuse_rt = 2'($urandom_range(0, 3));
            E_Tnew = 2'($urandom_range(0, 3)); M_Tnew = 2'($urandom_range(0, 3));
            D_flush = 1'($urandom_range(0, 1));
            s = ref_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew) |
                ref_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
            sb.push_back(make_exp(s, D_flush & ~s, 1'b0, "random_hazard"));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s[%0d]: got %b expected %b", e.name, i, outs, e.vec);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_md_window(input logic is_div);
        exp_t e;
        int   lat;
        lat = is_div ? 10 : 5;
        for (int c = 0; c <= lat + 1; c++) begin
            drive_idle();
            if (c == 0) begin
                E_md_start = 1'b1; E_md_is_div = is_div;
            end else begin
                D_is_md = 1'b1;
            end
            sb.push_back(make_exp(c >= 1 && c <= lat, 1'b0, c <= lat,
                                  is_div ? "div_window" : "mult_window"));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s[cycle %0d]: got %b expected %b", e.name, c, outs, e.vec);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_vs_stall();
        exp_t e;
        for (int c = 0; c <= 6; c++) begin
            drive_idle();
            if (c == 0) begin
                E_md_start = 1'b1;
                sb.push_back(make_exp(1'b0, 1'b0, 1'b1, "flush_vs_stall"));
            end else begin
                D_is_md = 1'b1; D_flush = 1'b1;
                sb.push_back(make_exp(c <= 5, c == 6, c <= 5, "flush_vs_stall"));
            end
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s[cycle %0d]: got %b expected %b", e.name, c, outs, e.vec);
            end
            @(posedge clk); #1;
        end
    endtask

    // Divide started, then a multiply restarts the window at cycle 3 (5 more busy cycles).
    task automatic test_back_to_back();
        exp_t e;
        for (int c = 0; c <= 9; c++) begin
            drive_idle();
            if (c == 0) begin
                E_md_start = 1'b1; E_md_is_div = 1'b1;
                sb.push_back(make_exp(1'b0, 1'b0, 1'b1, "md_reload"));
            end else begin
                D_is_md = 1'b1;
                if (c == 3) E_md_start = 1'b1;
                sb.push_back(make_exp(c <= 8, 1'b0, c <= 8, "md_reload"));
            end
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s[cycle %0d]: got %b expected %b", e.name, c, outs, e.vec);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_divide();
        exp_t e;
        for (int c = 0; c <= 6; c++) begin
            drive_idle();
            reset = (c == 4);
            if (c == 0) begin
                E_md_start = 1'b1; E_md_is_div = 1'b1;
                sb.push_back(make_exp(1'b0, 1'b0, 1'b1, "reset_mid_div"));
            end else begin
                D_is_md = 1'b1;
                sb.push_back(make_exp(c <= 4, 1'b0, c <= 4, "reset_mid_div"));
            end
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s[cycle %0d]: got %b expected %b", e.name, c, outs, e.vec);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

`ifdef STALL_PERF_CNT_EN
    task automatic test_perf_counter();
        drive_idle();
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
        E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        drive_idle();
        @(negedge clk);
        checks++;
        if (stall_cycles !== 32'd7) begin
            errors++;
            $display("[TB] FAIL perf_count: got %0d expected 7", stall_cycles);
        end
        @(posedge clk); #1;
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("[TB] FAIL perf_clear: got %0d expected 0", stall_cycles);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive_idle();
`ifdef STALL_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        test_reset();
        test_load_use();
        test_zero_reg();
        test_random_hazards();
        test_md_window(1'b1);
        test_md_window(1'b0);
        test_flush_vs_stall();
        test_back_to_back();
        test_reset_mid_divide();
`ifdef STALL_PERF_CNT_EN
        test_perf_counter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
